bp_ctrl: RTL and testbench

Branch-prediction controller between the fetch-stage predictor (BHT/BTB) and the execute-stage branch unit. It carries each fetched instruction's prediction through the IF/ID and ID/EX pipeline registers. It selects the next fetch PC, detects mispredictions in EX, and raises flushes for the wrongly fetched instructions. It also drives the predictor's EX-side update inputs and keeps saturating branch/mispredict counters.

---
 rtl/bp_pkg.sv | 15 +
 rtl/bp_ctrl_if.sv | 43 ++++
 rtl/bp_stage_reg.sv | 36 +++
 rtl/bp_ctrl.sv | 89 ++++++++
 tb/tb_bp_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/bp_pkg.sv
// Shared types and constants for the branch-prediction controller.
package bp_pkg;

    localparam logic [31:0] PC_INC = 32'd4;
    localparam logic [31:0] RST_PC = 32'd0;

    // Prediction state carried alongside an instruction through IF/ID and ID/EX.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        pred;
        logic [31:0] npc_pred;
    } bp_stage_t;

endpackage

// File: rtl/bp_ctrl_if.sv
// Fetch/execute-side signal bundle of the branch-prediction controller.
interface bp_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    // Fetch side
    logic [31:0]      PCF;
    logic             PredF;
    logic [31:0]      NPC_PredF;
    // Pipeline control
    logic             StallD;
    logic             StallE;
    logic             FlushD_ext;
    logic             FlushE_ext;
    // Execute-side resolution
    logic             IsBranchE;
    logic             BranchE;
    logic [31:0]      BrNPC;
    // Outputs
    logic [31:0]      NPC;
    logic [31:0]      PCE;
    logic             PredE;
    logic [31:0]      NPC_PredE;
    logic             FlushD_br;
    logic             FlushE_br;
    logic             MispredE;
    logic [CNT_W-1:0] BrCnt;
    logic [CNT_W-1:0] MispredCnt;

    modport master (
        output PCF, PredF, NPC_PredF, StallD, StallE, FlushD_ext, FlushE_ext,
        output IsBranchE, BranchE, BrNPC,
        input  NPC, PCE, PredE, NPC_PredE, FlushD_br, FlushE_br, MispredE,
        input  BrCnt, MispredCnt
    );

    modport slave (
        input  PCF, PredF, NPC_PredF, StallD, StallE, FlushD_ext, FlushE_ext,
        input  IsBranchE, BranchE, BrNPC,
        output NPC, PCE, PredE, NPC_PredE, FlushD_br, FlushE_br, MispredE,
        output BrCnt, MispredCnt
    );

endinterface

// File: rtl/bp_stage_reg.sv
// One pipeline stage of prediction state; priority is reset > flush > stall > bubble > load.
module bp_stage_reg
    import bp_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      stall,
    input  logic      flush,
    input  logic      bubble,
    input  bp_stage_t d,
    output bp_stage_t q
);

    localparam bp_stage_t StageClr = '{valid: 1'b0, pc: RST_PC, pred: 1'b0, npc_pred: 32'd0};

    bp_stage_t stage_q, stage_d;

    // Next-state: flush beats stall; a non-stalled bubble inserts an empty slot.
    always_comb begin
        stage_d = stage_q;
        if (flush) begin
            stage_d = StageClr;
        end else if (!stall) begin
            stage_d = bubble ? StageClr : d;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) stage_q <= StageClr;
        else     stage_q <= stage_d;
    end

    assign q = stage_q;

endmodule

// File: rtl/bp_ctrl.sv
// Branch-prediction controller: carries predictions to EX, resolves mispredicts,
// selects the next fetch PC and keeps saturating branch/mispredict counters.
module bp_ctrl
    import bp_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input logic     clk,
    input logic     rst,
    bp_ctrl_if.slave bus
);

    bp_stage_t d_in, d_q, e_q;
    logic      pred_e, res, mis_nt, mis_t, mispred;
    logic [31:0] pce_inc, pcf_inc;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d, mis_cnt_q, mis_cnt_d;

    assign d_in = '{valid: 1'b1, pc: bus.PCF, pred: bus.PredF, npc_pred: bus.NPC_PredF};

    bp_stage_reg u_stage_d (
        .clk    (clk),
        .rst    (rst),
        .stall  (bus.StallD),
        .flush  (bus.FlushD_ext | mispred),
        .bubble (1'b0),
        .d      (d_in),
        .q      (d_q)
    );

    // A stalled D feeding a moving E must not duplicate the instruction.
    bp_stage_reg u_stage_e (
        .clk    (clk),
        .rst    (rst),
        .stall  (bus.StallE),
        .flush  (bus.FlushE_ext | mispred),
        .bubble (bus.StallD),
        .d      (d_q),
        .q      (e_q)
    );

    // Resolution: only a valid, non-stalled EX instruction may redirect or count.
    always_comb begin
        pred_e  = e_q.valid & e_q.pred;
        res     = e_q.valid & ~bus.StallE;
        mis_nt  = res & pred_e & ~(bus.IsBranchE & bus.BranchE);
        mis_t   = res & bus.IsBranchE & bus.BranchE &
                  (~pred_e | (e_q.npc_pred != bus.BrNPC));
        mispred = mis_nt | mis_t;
    end

    // Next fetch PC: EX redirects beat the fetch-stage prediction.
    always_comb begin
        pce_inc = e_q.pc + PC_INC;
        pcf_inc = bus.PCF + PC_INC;
        if (mis_t)            bus.NPC = bus.BrNPC;
        else if (mis_nt)      bus.NPC = pce_inc;
        else if (bus.PredF)   bus.NPC = bus.NPC_PredF;
        else                  bus.NPC = pcf_inc;
    end

    // Counter next-state, holding at all-ones.
    always_comb begin
        br_cnt_d  = br_cnt_q;
        mis_cnt_d = mis_cnt_q;
        if (res && bus.IsBranchE && (br_cnt_q != '1)) br_cnt_d  = br_cnt_q + CNT_W'(1);
        if (mispred && (mis_cnt_q != '1))             mis_cnt_d = mis_cnt_q + CNT_W'(1);
    end

    // Counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else begin
            br_cnt_q  <= br_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

    assign bus.PCE        = e_q.pc;
    assign bus.PredE      = pred_e;
    assign bus.NPC_PredE  = e_q.npc_pred;
    assign bus.FlushD_br  = mispred;
    assign bus.FlushE_br  = mispred;
    assign bus.MispredE   = mispred;
    assign bus.BrCnt      = br_cnt_q;
    assign bus.MispredCnt = mis_cnt_q;

endmodule

// File: tb/tb_bp_ctrl.sv
// Directed self-checking bench for bp_ctrl (counters built 4 bits wide).
module tb_bp_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    bp_ctrl_if #(.CNT_W(4)) bus ();

    bp_ctrl #(.CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.PCF = 32'h0; bus.PredF = 1'b0; bus.NPC_PredF = 32'h0;
        bus.StallD = 1'b0; bus.StallE = 1'b0; bus.FlushD_ext = 1'b0; bus.FlushE_ext = 1'b0;
        bus.IsBranchE = 1'b0; bus.BranchE = 1'b0; bus.BrNPC = 32'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.PCF = 32'h100;
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        #1;
        total++; if (bus.NPC !== 32'h104) begin bad++; $display("FAIL reset_npc got=%h want=%h", bus.NPC, 32'h104); end
        total++; if (bus.PredE !== 1'b0) begin bad++; $display("FAIL reset_prede got=%b want=0", bus.PredE); end
        total++; if (bus.PCE !== 32'h0 || bus.NPC_PredE !== 32'h0) begin bad++; $display("FAIL reset_e got pce=%h npcp=%h want 0", bus.PCE, bus.NPC_PredE); end
        total++; if ({bus.MispredE, bus.FlushD_br, bus.FlushE_br} !== 3'b000) begin bad++; $display("FAIL reset_flush got=%b want=000", {bus.MispredE, bus.FlushD_br, bus.FlushE_br}); end
        total++; if (bus.BrCnt !== 4'h0 || bus.MispredCnt !== 4'h0) begin bad++; $display("FAIL reset_cnt got br=%h mis=%h want 0", bus.BrCnt, bus.MispredCnt); end
        bus.PredF = 1'b1; bus.NPC_PredF = 32'h500;
        #1;
        total++; if (bus.NPC !== 32'h500) begin bad++; $display("FAIL reset_npc_pred got=%h want=%h", bus.NPC, 32'h500); end
    endtask

    task automatic test_correct_taken();
        do_reset();
        bus.PCF = 32'h200; bus.PredF = 1'b1; bus.NPC_PredF = 32'h300;
        step();
        bus.PCF = 32'h300; bus.PredF = 1'b0;
        step();
        bus.PCF = 32'h304; bus.IsBranchE = 1'b1; bus.BranchE = 1'b1; bus.BrNPC = 32'h300;
        #1;
        total++; if (bus.PCE !== 32'h200 || bus.PredE !== 1'b1 || bus.NPC_PredE !== 32'h300) begin bad++; $display("FAIL ct_carry got pce=%h pred=%b npcp=%h want 200/1/300", bus.PCE, bus.PredE, bus.NPC_PredE); end
        total++; if (bus.MispredE !== 1'b0 || bus.FlushD_br !== 1'b0) begin bad++; $display("FAIL ct_mispred got=%b want=0", bus.MispredE); end
        total++; if (bus.NPC !== 32'h308) begin bad++; $display("FAIL ct_npc got=%h want=%h", bus.NPC, 32'h308); end
        step();
        bus.IsBranchE = 1'b0; bus.BranchE = 1'b0;
        #1;
        total++; if (bus.BrCnt !== 4'h1 || bus.MispredCnt !== 4'h0) begin bad++; $display("FAIL ct_cnt got br=%h mis=%h want 1/0", bus.BrCnt, bus.MispredCnt); end
    endtask

    task automatic test_wrong_taken();
        do_reset();
        bus.PCF = 32'h200; bus.PredF = 1'b1; bus.NPC_PredF = 32'h300;
        step();
        bus.PCF = 32'h300; bus.PredF = 1'b0;
        step();
        bus.PCF = 32'h304; bus.IsBranchE = 1'b1; bus.BranchE = 1'b0; bus.BrNPC = 32'h300;
        #1;
        total++; if (bus.NPC !== 32'h204) begin bad++; $display("FAIL wt_npc got=%h want=%h", bus.NPC, 32'h204); end
        total++; if ({bus.MispredE, bus.FlushD_br, bus.FlushE_br} !== 3'b111) begin bad++; $display("FAIL wt_flush got=%b want=111", {bus.MispredE, bus.FlushD_br, bus.FlushE_br}); end
        step();
        bus.PCF = 32'h204; bus.BranchE = 1'b1; bus.BrNPC = 32'h900;
        #1;
        total++; if (bus.PredE !== 1'b0 || bus.MispredE !== 1'b0) begin bad++; $display("FAIL wt_bubble got pred=%b mis=%b want 0/0", bus.PredE, bus.MispredE); end
        total++; if (bus.NPC !== 32'h208) begin bad++; $display("FAIL wt_npc_after got=%h want=%h", bus.NPC, 32'h208); end
        total++; if (bus.MispredCnt !== 4'h1 || bus.BrCnt !== 4'h1) begin bad++; $display("FAIL wt_cnt got br=%h mis=%h want 1/1", bus.BrCnt, bus.MispredCnt); end
    endtask

    task automatic test_target_mismatch();
        do_reset();
        bus.PCF = 32'h200; bus.PredF = 1'b1; bus.NPC_PredF = 32'h300;
        step();
        bus.PCF = 32'h300; bus.PredF = 1'b0;
        step();
        // Fetch-side prediction present too; the EX redirect must win.
        bus.PCF = 32'h304; bus.PredF = 1'b1; bus.NPC_PredF = 32'h999;
        bus.IsBranchE = 1'b1; bus.BranchE = 1'b1; bus.BrNPC = 32'h340;
        #1;
        total++; if (bus.NPC !== 32'h340) begin bad++; $display("FAIL tm_npc got=%h want=%h", bus.NPC, 32'h340); end
        total++; if (bus.MispredE !== 1'b1) begin bad++; $display("FAIL tm_mispred got=%b want=1", bus.MispredE); end
        step();
        idle_inputs();
        #1;
        total++; if (bus.MispredCnt !== 4'h1 || bus.BrCnt !== 4'h1) begin bad++; $display("FAIL tm_cnt got br=%h mis=%h want 1/1", bus.BrCnt, bus.MispredCnt); end
    endtask

    task automatic test_stall_hold();
        do_reset();
        bus.PCF = 32'h400;
        step();
        bus.PCF = 32'h404;
        step();
        bus.StallD = 1'b1; bus.StallE = 1'b1; bus.PCF = 32'h408;
        bus.IsBranchE = 1'b1; bus.BranchE = 1'b1; bus.BrNPC = 32'h800;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (bus.MispredE !== 1'b0 || bus.FlushD_br !== 1'b0 || bus.FlushE_br !== 1'b0) begin bad++; $display("FAIL st_hold%0d got mis=%b want 0", i, bus.MispredE); end
            total++; if (bus.NPC !== 32'h40c) begin bad++; $display("FAIL st_npc%0d got=%h want=%h", i, bus.NPC, 32'h40c); end
            step();
        end
        total++; if (bus.MispredCnt !== 4'h0 || bus.BrCnt !== 4'h0) begin bad++; $display("FAIL st_cnt_held got br=%h mis=%h want 0/0", bus.BrCnt, bus.MispredCnt); end
        bus.StallD = 1'b0; bus.StallE = 1'b0;
        #1;
        total++; if (bus.MispredE !== 1'b1 || bus.NPC !== 32'h800) begin bad++; $display("FAIL st_release got mis=%b npc=%h want 1/800", bus.MispredE, bus.NPC); end
        step();
        step();
        bus.IsBranchE = 1'b0;
        #1;
        total++; if (bus.MispredCnt !== 4'h1 || bus.BrCnt !== 4'h1) begin bad++; $display("FAIL st_cnt got br=%h mis=%h want 1/1", bus.BrCnt, bus.MispredCnt); end
    endtask

    task automatic test_flush_over_stall();
        do_reset();
        bus.PCF = 32'h600; bus.PredF = 1'b1; bus.NPC_PredF = 32'h700;
        step();
        bus.PredF = 1'b0; bus.StallD = 1'b1; bus.FlushD_ext = 1'b1;
        step();
        bus.StallD = 1'b0; bus.FlushD_ext = 1'b0;
        step();
        #1;
        total++; if (bus.PredE !== 1'b0 || bus.MispredE !== 1'b0) begin bad++; $display("FAIL fd_cleared got pred=%b mis=%b want 0/0", bus.PredE, bus.MispredE); end
        // E-side: predicted-taken non-branch aliases as a mispredict, then flush beats stall.
        do_reset();
        bus.PCF = 32'h600; bus.PredF = 1'b1; bus.NPC_PredF = 32'h700;
        step();
        bus.PCF = 32'h700; bus.PredF = 1'b0;
        step();
        bus.PCF = 32'h704;
        #1;
        total++; if (bus.PredE !== 1'b1 || bus.MispredE !== 1'b1 || bus.NPC !== 32'h604) begin bad++; $display("FAIL alias got pred=%b mis=%b npc=%h want 1/1/604", bus.PredE, bus.MispredE, bus.NPC); end
        bus.StallE = 1'b1; bus.StallD = 1'b1; bus.FlushE_ext = 1'b1;
        step();
        bus.FlushE_ext = 1'b0;
        #1;
        total++; if (bus.PredE !== 1'b0 || bus.PCE !== 32'h0) begin bad++; $display("FAIL fe_cleared got pred=%b pce=%h want 0/0", bus.PredE, bus.PCE); end
        total++; if (bus.MispredCnt !== 4'h0) begin bad++; $display("FAIL fe_cnt got=%h want 0", bus.MispredCnt); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.PCF = 32'h200; bus.PredF = 1'b1; bus.NPC_PredF = 32'h300;
        step();
        bus.PredF = 1'b0; bus.PCF = 32'h300;
        step();
        bus.IsBranchE = 1'b1; bus.BranchE = 1'b0;
        rst = 1'b1;
        #1;
        total++; if (bus.MispredE !== 1'b1) begin bad++; $display("FAIL rm_pending got=%b want=1", bus.MispredE); end
        step();
        rst = 1'b0;
        #1;
        total++; if (bus.MispredCnt !== 4'h0 || bus.BrCnt !== 4'h0 || bus.PredE !== 1'b0 || bus.PCE !== 32'h0) begin bad++; $display("FAIL rm_state got br=%h mis=%h pred=%b pce=%h want 0", bus.BrCnt, bus.MispredCnt, bus.PredE, bus.PCE); end
    endtask

    task automatic test_sat_wrap();
        do_reset();
        bus.PCF = 32'h1000; bus.PredF = 1'b1; bus.NPC_PredF = 32'h2000;
        bus.IsBranchE = 1'b1; bus.BranchE = 1'b0;
        // Each mispredict flushes both stages, so one resolves every 3 cycles: 20 in 60.
        for (int i = 0; i < 60; i++) step();
        #1;
        total++; if (bus.BrCnt !== 4'hf || bus.MispredCnt !== 4'hf) begin bad++; $display("FAIL sat got br=%h mis=%h want f/f", bus.BrCnt, bus.MispredCnt); end
        do_reset();
        bus.PCF = 32'hffff_fffc;
        #1;
        total++; if (bus.NPC !== 32'h0) begin bad++; $display("FAIL wrap_pcf got=%h want=0", bus.NPC); end
        bus.PredF = 1'b1; bus.NPC_PredF = 32'h10;
        step();
        bus.PCF = 32'h10; bus.PredF = 1'b0;
        step();
        bus.PCF = 32'h14; bus.IsBranchE = 1'b1; bus.BranchE = 1'b0;
        #1;
        total++; if (bus.NPC !== 32'h0 || bus.MispredE !== 1'b1) begin bad++; $display("FAIL wrap_pce got npc=%h mis=%b want 0/1", bus.NPC, bus.MispredE); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_correct_taken();
        test_wrong_taken();
        test_target_mismatch();
        test_stall_hold();
        test_flush_over_stall();
        test_reset_mid();
        test_sat_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
